bm_if_case_pipe: RTL and testbench

Parametrised successor of the two-bit if/case micro benchmark. It generalises operand width and adds a synchronous reset, a valid/enable-qualified two-stage pipeline, width-generic case-decoded hold registers and a saturating gated-transaction counter. It is a standalone regression micro block that exercises if/else priority, partial case assignment (inferred hold), pipeline stall and saturation logic in synthesis.

---
 rtl/bm_if_case_pipe.sv | 82 ++++++++
 tb/tb_bm_if_case_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bm_if_case_pipe.sv
// Two-stage valid-qualified AND pipeline with case-decoded hold registers
// and a saturating counter of gated (c_in=0) transactions.
module bm_if_case_pipe #(
    parameter int BITS     = 2,
    parameter int CNT_BITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic                valid_in,
    input  logic [BITS-1:0]     a_in,
    input  logic [BITS-1:0]     b_in,
    input  logic                c_in,
    input  logic                d_in,
    output logic [BITS-1:0]     out0,
    output logic                out1,
    output logic [BITS-1:0]     out2,
    output logic                valid_out,
    output logic [CNT_BITS-1:0] gate_cnt
);

    logic [BITS-1:0] and_p1;
    logic            bit_p1;
    logic            vld_p1;
    logic [BITS-1:0] hold_a;
    logic [BITS-1:0] hold_b;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + CNT_BITS'(1);
    endfunction

    // Stage 1: gated operands, valid, and the selector-decoded hold registers
    always_ff @(posedge clock) begin
        if (reset) begin
            and_p1 <= '0;
            bit_p1 <= 1'b0;
            vld_p1 <= 1'b0;
            hold_a <= '0;
            hold_b <= '0;
        end else if (en) begin
            vld_p1 <= valid_in;
            if (valid_in && c_in) begin
                and_p1 <= a_in & b_in;
                bit_p1 <= d_in;
            end else begin
                and_p1 <= '0;
                bit_p1 <= 1'b0;
            end
            // Each branch writes only one hold register; the other keeps its value.
            if (valid_in) begin
                case (a_in == '0)
                    1'b1:    hold_b <= '1;
                    default: hold_a <= ~a_in;
                endcase
            end
        end
    end

    // Stage 2: registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            out0      <= '0;
            out1      <= 1'b0;
            out2      <= '0;
            valid_out <= 1'b0;
        end else if (en) begin
            out0      <= and_p1;
            out1      <= bit_p1;
            out2      <= hold_a & hold_b;
            valid_out <= vld_p1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gate_cnt <= '0;
        end else if (en && valid_in && !c_in) begin
            gate_cnt <= sat_inc(gate_cnt);
        end
    end

endmodule

// File: tb/tb_bm_if_case_pipe.sv
// Bench for bm_if_case_pipe: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, and a randomized phase.
module tb_bm_if_case_pipe;

    localparam int BITS     = 2;
    localparam int CNT_BITS = 4;
    localparam int CMAX     = (1 << CNT_BITS) - 1;

    logic                clock = 1'b0;
    logic                reset, en, valid_in, c_in, d_in;
    logic [BITS-1:0]     a_in, b_in;
    logic [BITS-1:0]     out0, out2;
    logic                out1, valid_out;
    logic [CNT_BITS-1:0] gate_cnt;

    logic [4:0] a5, b5, o5_0, o5_2;
    logic       o5_1, v5_out;
    logic [3:0] cnt5;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bm_if_case_pipe #(.BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
        .clock(clock), .reset(reset), .en(en), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .out0(out0), .out1(out1), .out2(out2), .valid_out(valid_out),
        .gate_cnt(gate_cnt)
    );

    bm_if_case_pipe #(.BITS(5), .CNT_BITS(4)) dut5 (
        .clock(clock), .reset(reset), .en(en), .valid_in(valid_in),
        .a_in(a5), .b_in(b5), .c_in(c_in), .d_in(d_in),
        .out0(o5_0), .out1(o5_1), .out2(o5_2), .valid_out(v5_out),
        .gate_cnt(cnt5)
    );

    // Reference model: each advancing edge produces the output record that
    // becomes visible one advancing edge later.
    typedef struct {
        logic [BITS-1:0] o0;
        logic            o1;
        logic [BITS-1:0] o2;
        logic            v;
    } rec_t;

    rec_t            m_cur, m_pend;
    logic [BITS-1:0] m_last_nonzero_inv;
    logic            m_seen_zero;
    int              m_cnt;
    bit              armed = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_cur              = '{o0: '0, o1: 1'b0, o2: '0, v: 1'b0};
            m_pend             = m_cur;
            m_last_nonzero_inv = '0;
            m_seen_zero        = 1'b0;
            m_cnt              = 0;
            armed              = 1'b1;
        end else if (en) begin
            if (valid_in) begin
                if (a_in == 0) m_seen_zero = 1'b1;
                else           m_last_nonzero_inv = ~a_in;
            end
            if (valid_in && !c_in && m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_cur     = m_pend;
            m_pend.v  = valid_in;
            m_pend.o0 = (valid_in && c_in) ? (a_in & b_in) : '0;
            m_pend.o1 = valid_in && c_in && d_in;
            m_pend.o2 = m_seen_zero ? m_last_nonzero_inv : '0;
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            checks++;
            if (out0 !== m_cur.o0 || out1 !== m_cur.o1 || out2 !== m_cur.o2 ||
                valid_out !== m_cur.v || gate_cnt !== CNT_BITS'(m_cnt)) begin
                errors++;
                $display("FAIL model t=%0t got o0=%b o1=%b o2=%b v=%b cnt=%0d want o0=%b o1=%b o2=%b v=%b cnt=%0d",
                         $time, out0, out1, out2, valid_out, gate_cnt,
                         m_cur.o0, m_cur.o1, m_cur.o2, m_cur.v, m_cnt);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic drive(input logic v, input logic c, input logic d,
                         input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        valid_in = v; c_in = c; d_in = d; a_in = a; b_in = b;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; a5 = '0; b5 = '0;
        drive(0, 0, 0, '0, '0);
        tick(2);
        reset = 1'b0; en = 1'b1;
        chk("reset_out0", 32'(out0), 0);
        chk("reset_valid", 32'(valid_out), 0);
        chk("reset_cnt", 32'(gate_cnt), 0);

        // Basic data path
        drive(1, 1, 1, 2'b11, 2'b10); tick();
        drive(0, 1, 1, 2'b11, 2'b10); tick();
        chk("s1_out0", 32'(out0), 32'b10);
        chk("s1_out1", 32'(out1), 1);
        chk("s1_valid", 32'(valid_out), 1);
        tick();
        chk("s1_valid_drop", 32'(valid_out), 0);
        chk("s1_out0_drop", 32'(out0), 0);

        // Hold registers and out2
        drive(1, 1, 0, 2'b00, 2'b00); tick();
        drive(1, 1, 0, 2'b01, 2'b00); tick();
        drive(0, 1, 0, 2'b01, 2'b00); tick();
        chk("s2_out2_10", 32'(out2), 32'b10);
        drive(1, 1, 0, 2'b11, 2'b00); tick();
        drive(0, 1, 0, 2'b00, 2'b00); tick();
        chk("s2_out2_00", 32'(out2), 0);
        tick(2);
        chk("s2_invalid_a0", 32'(out2), 0);

        // Gating and saturation
        drive(1, 0, 1, 2'b11, 2'b11);
        tick(15);
        chk("s3_cnt15", 32'(gate_cnt), 15);
        chk("s3_out0", 32'(out0), 0);
        chk("s3_out1", 32'(out1), 0);
        tick(5);
        chk("s3_cnt_sat", 32'(gate_cnt), 15);
        drive(0, 0, 1, 2'b11, 2'b11); tick(4);
        chk("s3_cnt_idle", 32'(gate_cnt), 15);

        // Stall with a transaction in stage 1
        drive(1, 1, 1, 2'b11, 2'b11); tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, i[0], 1, 2'(i), 2'(i + 1)); tick();
        end
        chk("s4_frozen_cnt", 32'(gate_cnt), 15);
        chk("s4_frozen_valid", 32'(valid_out), 0);
        en = 1'b1;
        drive(0, 1, 0, 2'b00, 2'b00); tick();
        chk("s4_emerge_out0", 32'(out0), 32'b11);
        chk("s4_emerge_valid", 32'(valid_out), 1);

        // Reset mid-operation
        reset = 1'b1; tick(); reset = 1'b0;
        drive(1, 0, 0, 2'b01, 2'b00); tick(7);
        drive(1, 1, 1, 2'b01, 2'b11); tick();
        drive(1, 1, 1, 2'b00, 2'b11); tick();
        drive(0, 1, 1, 2'b00, 2'b11); tick();
        chk("s5_cnt7", 32'(gate_cnt), 7);
        chk("s5_pre_out2", 32'(out2), 32'b10);
        en = 1'b0; reset = 1'b1; tick(); reset = 1'b0; en = 1'b1;
        chk("s5_out0", 32'(out0), 0);
        chk("s5_out2", 32'(out2), 0);
        chk("s5_cnt", 32'(gate_cnt), 0);
        drive(1, 1, 1, 2'b01, 2'b01); tick();
        drive(0, 1, 1, 2'b01, 2'b01); tick(2);
        chk("s5_out2_hold_b_clear", 32'(out2), 0);

        // Width scaling on the 5-bit instance
        drive(1, 1, 0, 2'b00, 2'b00);
        a5 = 5'b00000; b5 = 5'b00000; tick();
        a5 = 5'b00110; tick();
        a5 = 5'b10101; b5 = 5'b11100; tick();
        chk("s6_out2_w5", 32'(o5_2), 32'b11001);
        valid_in = 1'b0; tick();
        chk("s6_out0_w5", 32'(o5_0), 32'b10100);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            en    = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 1), $urandom_range(0, 2) != 0, $urandom_range(0, 1),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
